// File: rtl/ysyx_22050710_mdu_pkg.sv
// ysyx_22050710_mdu_pkg: ALU control codes, FSM states and width defaults for the multiply/divide unit
package ysyx_22050710_mdu_pkg;
  localparam int MDU_XLEN = 64;
  localparam int MDU_WLEN = 32;
  localparam logic [4:0] MUL  = 5'b11100;
  localparam logic [4:0] DIV  = 5'b11011;
  localparam logic [4:0] DIVU = 5'b11010;
  localparam logic [4:0] REM  = 5'b11101;
  localparam logic [4:0] REMU = 5'b11001;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  function automatic logic is_mdu(input logic [4:0] c);
    return c == MUL || c == DIV || c == DIVU || c == REM || c == REMU;
  endfunction
endpackage

// File: rtl/ysyx_22050710_mdu_divcore.sv
// ysyx_22050710_mdu_divcore: restoring divider on unsigned magnitudes, one quotient bit per step
module ysyx_22050710_mdu_divcore #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);
  logic [W-1:0] r, q, d;
  logic [W:0] sh;
  logic ge;
  assign sh = {r, q[W-1]};
  assign ge = sh >= {1'b0, d};
  assign quo = q;
  assign rem = r;
  // the partial remainder stays below the divisor, so it always fits W bits after restoring
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      q <= '0;
      d <= '0;
    end else if (start) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
    end else if (step) begin
      r <= ge ? sh[W-1:0] - d : sh[W-1:0];
      q <= {q[W-2:0], ge};
    end
endmodule

// File: rtl/ysyx_22050710_mdu.sv
// ysyx_22050710_mdu: iterative RV64M multiply/divide unit with valid/ready on both sides
// YSYX_22050710_MDU_EARLY_OUT_EN lets the multiplier stop once the remaining multiplier bits are zero
module ysyx_22050710_mdu
  import ysyx_22050710_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int WLEN = MDU_WLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_aluctr,
  input  logic            i_word_cut,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);
  localparam int CW = $clog2(XLEN);
`ifdef YSYX_22050710_MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t state, state_nx;
  logic [4:0] op_q;
  logic word_q, neg_q, zero_q, ovf_q;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] a_q, mcand, mplier, prod, quo, rem, res, res_w;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_v;
  logic sgn, is_div, sa, sb, div_zero, ovf, special, acc, last;
  assign o_ready = state == IDLE;
  always_comb begin
    sgn = i_aluctr != DIVU && i_aluctr != REMU;
    is_div = i_aluctr != MUL;
    a_ext = i_word_cut ? {{(XLEN-WLEN){sgn & i_src_a[WLEN-1]}}, i_src_a[WLEN-1:0]} : i_src_a;
    b_ext = i_word_cut ? {{(XLEN-WLEN){sgn & i_src_b[WLEN-1]}}, i_src_b[WLEN-1:0]} : i_src_b;
    sa = sgn & a_ext[XLEN-1];
    sb = sgn & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    min_v = i_word_cut ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && b_ext == '0;
    ovf = is_div && sgn && a_ext == min_v && b_ext == {XLEN{1'b1}};
    special = div_zero || ovf || (EARLY && !is_div && b_ext == '0);
    acc = i_valid && o_ready && !i_flush && is_mdu(i_aluctr);
    last = cnt == '0 || (EARLY && op_q == MUL && mplier[XLEN-1:1] == '0);
  end
  always_comb begin
    state_nx = state;
    if (i_flush) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = acc ? (special ? FIX : BUSY) : IDLE;
        BUSY: state_nx = last ? FIX : BUSY;
        FIX:  state_nx = DONE;
        DONE: state_nx = (o_out_valid && i_out_ready) ? IDLE : DONE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  // word results are formed at full width and then cut back to WLEN with sign extension
  always_comb begin
    res = op_q == MUL ? (neg_q ? -prod : prod)
        : (op_q == DIV || op_q == DIVU) ? (zero_q ? {XLEN{1'b1}} : ovf_q ? a_q : neg_q ? -quo : quo)
        : (zero_q ? a_q : ovf_q ? '0 : neg_q ? -rem : rem);
    res_w = word_q ? {{(XLEN-WLEN){res[WLEN-1]}}, res[WLEN-1:0]} : res;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      op_q <= '0;
      word_q <= 1'b0;
      neg_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      a_q <= '0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      cnt <= '0;
      o_rd <= '0;
      o_result <= '0;
      o_out_valid <= 1'b0;
    end else begin
      if (acc) begin
        op_q <= i_aluctr;
        word_q <= i_word_cut;
        neg_q <= i_aluctr == REM ? sa : sa ^ sb;
        zero_q <= div_zero;
        ovf_q <= ovf;
        a_q <= a_ext;
        mcand <= a_mag;
        mplier <= b_mag;
        prod <= '0;
        cnt <= i_word_cut ? CW'(WLEN-1) : CW'(XLEN-1);
        o_rd <= i_rd;
      end else if (state == BUSY) begin
        prod <= prod + (mplier[0] ? mcand : '0);
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - CW'(1);
      end
      if (state == FIX && !i_flush) o_result <= res_w;
      o_out_valid <= !i_flush && state == DONE && !(o_out_valid && i_out_ready);
    end
  ysyx_22050710_mdu_divcore #(.W(XLEN)) u_divcore (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .start(acc),
    .step(state == BUSY),
    .dividend(i_word_cut ? a_mag << WLEN : a_mag),
    .divisor(b_mag),
    .quo(quo),
    .rem(rem)
  );
endmodule

// File: tb/tb_ysyx_22050710_mdu.sv
// tb_ysyx_22050710_mdu: directed self-checking bench for the multiply/divide unit
module tb_ysyx_22050710_mdu;
  localparam logic [4:0] MUL = 5'b11100, DIV = 5'b11011, DIVU = 5'b11010, REM = 5'b11101, REMU = 5'b11001;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_word_cut = 1'b0, i_flush = 1'b0, i_out_ready = 1'b0;
  logic o_ready, o_out_valid;
  logic [4:0] i_aluctr = '0, i_rd = '0, o_rd;
  logic [63:0] i_src_a = '0, i_src_b = '0, o_result;
  int errors = 0, checks = 0;
  logic seen;
  always #5 i_clk = ~i_clk;
  ysyx_22050710_mdu dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_aluctr(i_aluctr), .i_word_cut(i_word_cut), .i_src_a(i_src_a), .i_src_b(i_src_b),
    .i_rd(i_rd), .i_flush(i_flush), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_result(o_result), .o_rd(o_rd)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [4:0] ctr, input logic w, input logic [63:0] a, input logic [63:0] b,
                    input logic [4:0] rd, input logic [63:0] exp, input int lat, input int hold);
    int n;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_aluctr = ctr;
    i_word_cut = w;
    i_src_a = a;
    i_src_b = b;
    i_rd = rd;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    n = 0;
    while (!o_out_valid && n < 150) begin
      @(posedge i_clk);
      #1 n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_result"}, o_result, exp);
    check({tag, "_rd"}, 64'(o_rd), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk);
      #1 check({tag, "_hold"}, {o_out_valid, o_result[62:0]}, {1'b1, exp[62:0]});
    end
    @(negedge i_clk);
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1 i_out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(o_out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(o_ready), 64'd1);
  endtask
  task automatic watch_quiet(input string tag, input int cycles);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge i_clk);
      #1 seen = seen | o_out_valid;
    end
    check({tag, "_no_valid"}, 64'(seen), 64'd0);
    check({tag, "_idle"}, 64'(o_ready), 64'd1);
  endtask
  initial begin
    repeat (3) @(posedge i_clk);
    #1 check("reset_state", {o_result[59:0], o_rd[1:0], o_out_valid, o_ready}, 64'd1);
    check("reset_rd", 64'(o_rd), 64'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    op("mul_neg", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
    op("mulw", MUL, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0000_8000_0000, 5'd4, 64'hFFFF_FFFF_8000_0000, 34, 0);
    op("div_zero", DIV, 1'b0, 64'h1234, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    op("remu_zero", REMU, 1'b0, 64'h1234, 64'd0, 5'd6, 64'h1234, 2, 0);
    op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'h8000_0000_0000_0000, 2, 0);
    op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd0, 2, 0);
    op("divw_ovf", DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_8000_0000, 2, 0);
    op("divu_big", DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'h7FFF_FFFF_FFFF_FFFC, 66, 0);
    op("rem_neg", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    op("div_neg", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    op("divuw", DIVU, 1'b1, 64'h0000_0001_0000_0010, 64'd3, 5'd13, 64'd5, 34, 0);
    op("remw_neg", REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    op("backpressure", MUL, 1'b0, 64'd6, 64'd7, 5'd15, 64'd42, 66, 10);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_aluctr = 5'b00000;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    check("non_mdu_ignored", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_aluctr = MUL;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    i_flush = 1'b0;
    check("flush_beats_valid", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_aluctr = DIV;
    i_word_cut = 1'b0;
    i_src_a = 64'd100;
    i_src_b = 64'd7;
    i_rd = 5'd20;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    check("busy_not_ready", 64'(o_ready), 64'd0);
    repeat (19) @(posedge i_clk);
    @(negedge i_clk) i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    check("flush_ready", 64'(o_ready), 64'd1);
    watch_quiet("flush", 80);
    op("mul_after_flush", MUL, 1'b0, 64'd3, 64'd5, 5'd21, 64'd15, 66, 0);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_aluctr = MUL;
    i_src_a = 64'd2;
    i_src_b = 64'd3;
    i_rd = 5'd22;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b0;
    #1 check("rst_ready_valid", {62'd0, o_ready, o_out_valid}, 64'd2);
    check("rst_result", o_result, 64'd0);
    check("rst_rd", 64'(o_rd), 64'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    watch_quiet("after_reset", 80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
